seven_segment_capture: RTL and testbench

- Monitors the multiplexed, active-low seven-segment bus driven to the board's 3-digit display: segments a–h plus three digit enables.
- Reconstructs the displayed decimal number as BCD digits and as a 10-bit binary value.
- Sits on the display pins as a loop-back checker, so the bench and on-chip self-test can compare the shown count with the internal counter.

---
 rtl/seven_segment_pkg.sv | 44 ++++
 rtl/segment_to_bcd.sv | 30 +++
 rtl/seven_segment_capture.sv | 205 ++++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants and helpers for the seven-segment loop-back capture block:
// active-low digit patterns, enable codes, FSM/slot encodings and BCD conversion.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  localparam logic [2:0] EN_UNITS = 3'b110;
  localparam logic [2:0] EN_TENS  = 3'b101;
  localparam logic [2:0] EN_HUND  = 3'b011;
  localparam logic [2:0] EN_BLANK = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SLOT_NONE  = 2'd0,
    SLOT_UNITS = 2'd1,
    SLOT_TENS  = 2'd2,
    SLOT_HUND  = 2'd3
  } slot_e;

  // h*100 + t*10 + u using shifts only; max 999 fits in 10 bits
  function automatic logic [9:0] bcd_to_bin(input logic [11:0] bcd);
    logic [9:0] h;
    logic [9:0] t;
    logic [9:0] u;
    h = {6'd0, bcd[11:8]};
    t = {6'd0, bcd[7:4]};
    u = {6'd0, bcd[3:0]};
    return (h << 3'd6) + (h << 3'd5) + (h << 3'd2) + (t << 3'd3) + (t << 3'd1) + u;
  endfunction

endpackage

// File: rtl/segment_to_bcd.sv
// Combinational inverse of the display's BCD-to-segment table; flags
// any pattern that is not one of the ten digit glyphs.
module segment_to_bcd
  import seven_segment_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       legal_o
);

  // Pattern lookup; unknown glyphs report digit 0 and clear legal
  always_comb begin
    digit_o = 4'd0;
    legal_o = 1'b1;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_capture.sv
// Loop-back checker on a multiplexed 3-digit active-low seven-segment bus:
// filters the scanned slots, rebuilds each frame and publishes BCD + binary.
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int SETTLE_CYCLES = 8,
  parameter int FRAME_TIMEOUT = 262144
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic        dp_in,
  input  logic [2:0]  en_in,
  output logic [11:0] digits,
  output logic [9:0]  value,
  output logic        value_valid,
  output logic        frame_error,
  output logic        stale
);

  localparam int CNT_W   = $clog2(SETTLE_CYCLES);
  localparam int STALE_W = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   SETTLE_MAX = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   SETTLE_HIT = CNT_W'(SETTLE_CYCLES - 2);
  localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(FRAME_TIMEOUT);

  logic [10:0]        sync1_q, sync2_q, last_q;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic               change_s, sample_s;
  logic [2:0]         en_s;
  logic [3:0]         digit_s;
  logic               legal_s;

  logic               slot_vld_q, slot_vld_d;
  slot_e              slot_kind_q, slot_kind_d;
  logic               slot_bad_q, slot_bad_d;
  logic [3:0]         slot_digit_q;

  state_e             state_q, state_d;
  logic [3:0]         units_q, units_d, tens_q, tens_d, hund_q, hund_d;
  logic               tens_seen_q, tens_seen_d, hund_seen_q, hund_seen_d;
  logic               bad_q, bad_d;
  logic [11:0]        digits_q, digits_d;
  logic [9:0]         value_q, value_d;
  logic               valid_q, valid_d, ferr_q, ferr_d, stale_q, stale_d;
  logic [STALE_W-1:0] stale_cnt_q, stale_cnt_d;

  // sync1 differing from sync2 means sync2 is about to change this edge
  assign change_s = (sync1_q != sync2_q);
  // re-sampling the value already taken would turn a glitch into a duplicate slot
  assign sample_s = !change_s && (settle_q == SETTLE_HIT) && (sync2_q != last_q);
  assign en_s     = sync2_q[10:8];

  segment_to_bcd u_decode (
    .seg_i   (sync2_q[7:1]),
    .digit_o (digit_s),
    .legal_o (legal_s)
  );

  // Settle counter saturates so each stable period yields at most one sample
  always_comb begin
    if (change_s) begin
      settle_d = '0;
    end else if (settle_q == SETTLE_MAX) begin
      settle_d = settle_q;
    end else begin
      settle_d = settle_q + CNT_W'(1);
    end
  end

  // Slot classification from the stable synchronized bus
  always_comb begin
    slot_vld_d  = sample_s && (en_s != EN_BLANK);
    slot_kind_d = SLOT_NONE;
    case (en_s)
      EN_UNITS: slot_kind_d = SLOT_UNITS;
      EN_TENS:  slot_kind_d = SLOT_TENS;
      EN_HUND:  slot_kind_d = SLOT_HUND;
      default:  slot_kind_d = SLOT_NONE;
    endcase
    slot_bad_d = (slot_kind_d == SLOT_NONE) || !legal_s || !sync2_q[0];
  end

  // Input synchronizer, stability filter and slot capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      last_q       <= '1;
      settle_q     <= '0;
      slot_vld_q   <= 1'b0;
      slot_kind_q  <= SLOT_NONE;
      slot_bad_q   <= 1'b0;
      slot_digit_q <= 4'd0;
    end else begin
      sync1_q      <= {en_in, seg_in, dp_in};
      sync2_q      <= sync1_q;
      last_q       <= sample_s ? sync2_q : last_q;
      settle_q     <= settle_d;
      slot_vld_q   <= slot_vld_d;
      slot_kind_q  <= slot_kind_d;
      slot_bad_q   <= slot_bad_d;
      slot_digit_q <= digit_s;
    end
  end

  // Frame assembly FSM, publish/discard decision and staleness tracking
  always_comb begin
    state_d     = state_q;
    units_d     = units_q;
    tens_d      = tens_q;
    hund_d      = hund_q;
    tens_seen_d = tens_seen_q;
    hund_seen_d = hund_seen_q;
    bad_d       = bad_q;
    digits_d    = digits_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;
    if (slot_vld_q && (slot_kind_q == SLOT_UNITS)) begin
      if (state_q == ST_OPEN) begin
        if (bad_q) begin
          ferr_d = 1'b1;
        end else begin
          valid_d  = 1'b1;
          digits_d = {hund_q, tens_q, units_q};
          value_d  = bcd_to_bin({hund_q, tens_q, units_q});
        end
      end else begin
        ferr_d = 1'b0;
      end
      state_d     = ST_OPEN;
      units_d     = slot_digit_q;
      tens_d      = 4'd0;
      hund_d      = 4'd0;
      tens_seen_d = 1'b0;
      hund_seen_d = 1'b0;
      bad_d       = slot_bad_q;
    end else if (slot_vld_q && (state_q == ST_OPEN)) begin
      case (slot_kind_q)
        SLOT_TENS: begin
          tens_d      = slot_digit_q;
          tens_seen_d = 1'b1;
          bad_d       = bad_q | tens_seen_q | slot_bad_q;
        end
        SLOT_HUND: begin
          hund_d      = slot_digit_q;
          hund_seen_d = 1'b1;
          bad_d       = bad_q | !tens_seen_q | hund_seen_q | slot_bad_q;
        end
        default: bad_d = 1'b1;
      endcase
    end else begin
      state_d = state_q;
    end
    if (valid_d) begin
      stale_cnt_d = '0;
    end else if (stale_cnt_q == STALE_MAX) begin
      stale_cnt_d = stale_cnt_q;
    end else begin
      stale_cnt_d = stale_cnt_q + STALE_W'(1);
    end
    stale_d = !valid_d && (stale_cnt_d == STALE_MAX);
  end

  // Frame state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      units_q     <= 4'd0;
      tens_q      <= 4'd0;
      hund_q      <= 4'd0;
      tens_seen_q <= 1'b0;
      hund_seen_q <= 1'b0;
      bad_q       <= 1'b0;
      digits_q    <= 12'd0;
      value_q     <= 10'd0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
      stale_q     <= 1'b0;
      stale_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      units_q     <= units_d;
      tens_q      <= tens_d;
      hund_q      <= hund_d;
      tens_seen_q <= tens_seen_d;
      hund_seen_q <= hund_seen_d;
      bad_q       <= bad_d;
      digits_q    <= digits_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
      stale_q     <= stale_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  assign digits      = digits_q;
  assign value       = value_q;
  assign value_valid = valid_q;
  assign frame_error = ferr_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed + random scan sequences checked against a frame-level model of the
// display: slots in, expected publish/discard events and shown number out.
module tb_seven_segment_capture;

  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 600;
  localparam int SLOT    = 40;
  localparam logic [2:0] EN_U = 3'b110;
  localparam logic [2:0] EN_T = 3'b101;
  localparam logic [2:0] EN_H = 3'b011;
  localparam logic [2:0] EN_B = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_in;
  logic        dp_in;
  logic [2:0]  en_in;
  logic [11:0] digits;
  logic [9:0]  value;
  logic        value_valid, frame_error, stale;

  int n_assert = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;

  logic [6:0] pat [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // reference model: the frame currently being assembled and the last shown number
  bit m_open;
  bit m_bad;
  int m_dig [3];
  bit m_seen [3];
  int exp_value;

  always #5 clk = ~clk;

  seven_segment_capture #(.SETTLE_CYCLES(SETTLE), .FRAME_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .dp_in(dp_in), .en_in(en_in),
    .digits(digits), .value(value), .value_valid(value_valid),
    .frame_error(frame_error), .stale(stale)
  );

  always @(negedge clk) begin
    if (value_valid) n_valid++;
    if (frame_error) n_err++;
    n_assert++;
    assert (!(value_valid && frame_error)) else begin
      n_fail++;
      $error("FAIL excl: valid=%0b error=%0b required not both", value_valid, frame_error);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic open_frame(input int d, input bit bad);
    m_open = 1'b1;
    m_bad  = bad;
    m_dig[0] = d; m_dig[1] = 0; m_dig[2] = 0;
    m_seen[0] = 1'b1; m_seen[1] = 1'b0; m_seen[2] = 1'b0;
  endtask

  // kind: 0 nothing, 1 publish val, 2 discard
  task automatic model_slot(input logic [2:0] en, input logic [6:0] seg, input logic dp,
                            output int kind, output int val);
    int lows, pos, d;
    bit bad;
    kind = 0; val = 0; lows = 0; d = -1; pos = -1;
    for (int i = 0; i < 3; i++) if (!en[i]) lows++;
    if (lows == 0) return;
    for (int i = 0; i < 10; i++) if (pat[i] == seg) d = i;
    bad = (lows > 1) || (d < 0) || (dp == 1'b0);
    if (lows == 1) pos = (en == EN_U) ? 0 : (en == EN_T) ? 1 : 2;
    if (d < 0) d = 0;
    if (!m_open) begin
      if (pos == 0) open_frame(d, bad);
      return;
    end
    if (pos == 0) begin
      if (m_bad) kind = 2;
      else begin
        kind = 1;
        val  = 100 * m_dig[2] + 10 * m_dig[1] + m_dig[0];
      end
      open_frame(d, bad);
    end else if (pos == 1) begin
      if (m_seen[1]) m_bad = 1'b1;
      m_seen[1] = 1'b1; m_dig[1] = d; m_bad = m_bad | bad;
    end else if (pos == 2) begin
      if (!m_seen[1] || m_seen[2]) m_bad = 1'b1;
      m_seen[2] = 1'b1; m_dig[2] = d; m_bad = m_bad | bad;
    end else begin
      m_bad = 1'b1;
    end
  endtask

  task automatic drive(input logic [2:0] en, input logic [6:0] seg, input logic dp, input int cycles);
    en_in = en; seg_in = seg; dp_in = dp;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic run_slot(input string tag, input logic [2:0] en, input logic [6:0] seg,
                          input logic dp, input bit glitch);
    int kind, val;
    n_valid = 0; n_err = 0;
    model_slot(en, seg, dp, kind, val);
    if (kind == 1) exp_value = val;
    if (glitch) begin
      drive(en, seg, dp, 15);
      drive(en, seg ^ 7'b1000000, dp, 3);
      drive(en, seg, dp, SLOT - 18);
    end else begin
      drive(en, seg, dp, SLOT);
    end
    check({tag, ".valid_pulses"}, n_valid, (kind == 1) ? 1 : 0);
    check({tag, ".error_pulses"}, n_err, (kind == 2) ? 1 : 0);
    check({tag, ".value"}, value, exp_value);
    check({tag, ".digits"}, digits, to_bcd(exp_value));
  endtask

  task automatic scan(input string tag, input int n, input int reps);
    for (int r = 0; r < reps; r++) begin
      run_slot(tag, EN_U, pat[n % 10], 1'b1, 1'b0);
      run_slot(tag, (n >= 10) ? EN_T : EN_B, pat[(n / 10) % 10], 1'b1, 1'b0);
      run_slot(tag, (n >= 100) ? EN_H : EN_B, pat[n / 100], 1'b1, 1'b0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".digits"}, digits, 12'd0);
    check({tag, ".value"}, value, 10'd0);
    check({tag, ".valid"}, value_valid, 1'b0);
    check({tag, ".error"}, frame_error, 1'b0);
    check({tag, ".stale"}, stale, 1'b0);
  endtask

  initial begin
    int kind, val, cyc, n;
    m_open = 1'b0; m_bad = 1'b0; exp_value = 0;
    reset = 1'b0; en_in = EN_B; seg_in = 7'h7F; dp_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b1;

    scan("s472", 472, 3);
    scan("s7", 7, 2);
    scan("s50", 50, 2);

    // illegal glyph in the tens slot discards that frame only
    run_slot("badseg", EN_U, pat[2], 1'b1, 1'b0);
    run_slot("badseg", EN_T, 7'b1111111, 1'b1, 1'b0);
    run_slot("badseg", EN_H, pat[4], 1'b1, 1'b0);
    scan("after_bad", 472, 2);

    // dp low in a digit slot
    run_slot("dp", EN_U, pat[1], 1'b1, 1'b0);
    run_slot("dp", EN_T, pat[3], 1'b0, 1'b0);
    scan("after_dp", 31, 2);

    // two enables low at once
    run_slot("multi", EN_U, pat[9], 1'b1, 1'b0);
    run_slot("multi", 3'b100, pat[8], 1'b1, 1'b0);
    scan("after_multi", 89, 2);

    // short glitch mid-slot
    run_slot("glitch", EN_U, pat[6], 1'b1, 1'b0);
    run_slot("glitch", EN_T, pat[5], 1'b1, 1'b1);
    run_slot("glitch", EN_H, pat[2], 1'b1, 1'b1);
    run_slot("glitch", EN_U, pat[6], 1'b1, 1'b0);

    repeat (5) begin
      n = int'($urandom_range(0, 999));
      scan("rand", n, 2);
    end

    // stop scanning right after a publish; stale must follow TIMEOUT cycles later
    scan("pre_stale", 123, 1);
    model_slot(EN_U, pat[3], 1'b1, kind, val);
    en_in = EN_U; seg_in = pat[3]; dp_in = 1'b1;
    cyc = 0;
    while (!value_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("stale.pub_seen", value_valid, 1'b1);
    check("stale.pub_value", value, val);
    check("stale.before", stale, 1'b0);
    exp_value = val;
    en_in = EN_B;
    cyc = 0;
    while (!stale && cyc < TIMEOUT + 50) begin
      @(negedge clk);
      cyc++;
    end
    check("stale.delay", cyc, TIMEOUT);
    @(posedge clk);
    #1;
    run_slot("stale_clear", EN_U, pat[5], 1'b1, 1'b0);
    check("stale.cleared", stale, 1'b0);

    // reset in the middle of a frame
    run_slot("midrst", EN_T, pat[8], 1'b1, 1'b0);
    en_in = EN_B; seg_in = 7'h7F;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("midrst");
    reset = 1'b1;
    m_open = 1'b0; m_bad = 1'b0; exp_value = 0;
    run_slot("post_rst", EN_H, pat[9], 1'b1, 1'b0);
    run_slot("post_rst", EN_U, pat[1], 1'b1, 1'b0);
    run_slot("post_rst", EN_T, pat[2], 1'b1, 1'b0);
    run_slot("post_rst", EN_H, pat[3], 1'b1, 1'b0);
    run_slot("post_rst", EN_U, pat[4], 1'b1, 1'b0);
    check("post_rst.final", value, 10'd321);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
